// File: rtl/savestate_ctrl.sv
// Save-state sequencer: pauses the core, launches one memory_stream transfer for a slot,
// waits for it to drain, resumes the core and reports a status. Tracks which slots hold a save.
module savestate_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          SLOT_SIZE_LOG2 = 22,
  parameter int          NUM_SLOTS      = 4,
  parameter int          TIMEOUT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_save,
  input  logic                 cmd_load,
  input  logic [3:0]           cmd_slot,
  output logic                 cmd_ready,
  output logic                 core_pause_req,
  input  logic                 core_paused,
  output logic [31:0]          ms_start_addr,
  output logic [31:0]          ms_length,
  output logic                 ms_read_start,
  output logic                 ms_write_start,
  input  logic                 ms_busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [NUM_SLOTS-1:0] slot_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_START, S_RUN, S_RESUME, S_DONE
  } state_t;

  typedef struct packed {
    logic       save;
    logic [3:0] slot;
  } op_t;

  localparam logic [1:0]  ST_OK      = 2'd0;
  localparam logic [1:0]  ST_TIMEOUT = 2'd1;
  localparam logic [1:0]  ST_BADSLOT = 2'd2;
  localparam logic [1:0]  ST_EMPTY   = 2'd3;
  localparam logic [31:0] SLOT_BYTES = 32'd1 << SLOT_SIZE_LOG2;
  localparam logic [31:0] NUM_SLOTS_W = 32'(NUM_SLOTS);

  state_t               state;
  op_t                  op_q;
  logic [TIMEOUT_W-1:0] timer;
  logic                 run_first;
  logic                 slot_has_data;
  logic                 slot_in_range;
  logic                 timer_expired;

  // Decoded lookup keeps out-of-range slot indices away from slot_valid.
  always_comb begin
    slot_has_data = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (cmd_slot == 4'(i)) slot_has_data = slot_valid[i];
  end

  assign slot_in_range = {28'd0, cmd_slot} < NUM_SLOTS_W;
  assign timer_expired = (timer == {TIMEOUT_W{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      op_q           <= '0;
      timer          <= '0;
      run_first      <= 1'b0;
      cmd_ready      <= 1'b1;
      core_pause_req <= 1'b0;
      ms_start_addr  <= '0;
      ms_length      <= '0;
      ms_read_start  <= 1'b0;
      ms_write_start <= 1'b0;
      done           <= 1'b0;
      status         <= ST_OK;
      slot_valid     <= '0;
    end else begin
      ms_read_start  <= 1'b0;
      ms_write_start <= 1'b0;
      done           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_save || cmd_load) begin
            op_q.save <= cmd_save;
            op_q.slot <= cmd_slot;
            cmd_ready <= 1'b0;
            if (!slot_in_range) begin
              status <= ST_BADSLOT;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (!cmd_save && !slot_has_data) begin
              status <= ST_EMPTY;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              core_pause_req <= 1'b1;
              timer          <= '0;
              ms_start_addr  <= BASE_ADDR + ({28'd0, cmd_slot} << SLOT_SIZE_LOG2);
              ms_length      <= SLOT_BYTES;
              state          <= S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (core_paused && !ms_busy) begin
            ms_write_start <= op_q.save;
            ms_read_start  <= !op_q.save;
            state          <= S_START;
          end else if (timer_expired) begin
            core_pause_req <= 1'b0;
            status         <= ST_TIMEOUT;
            done           <= 1'b1;
            state          <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_START: begin
          run_first <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          // The stream engine only raises busy a cycle after the start pulse.
          if (run_first) begin
            run_first <= 1'b0;
          end else if (!ms_busy) begin
            core_pause_req <= 1'b0;
            timer          <= '0;
            state          <= S_RESUME;
          end
        end
        S_RESUME: begin
          if (!core_paused || timer_expired) begin
            status <= core_paused ? ST_TIMEOUT : ST_OK;
            done   <= 1'b1;
            state  <= S_DONE;
            // Data is in memory either way, so a save marks the slot even on timeout.
            if (op_q.save)
              for (int i = 0; i < NUM_SLOTS; i++)
                if (op_q.slot == 4'(i)) slot_valid[i] <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cmd_ready      <= 1'b1;
          core_pause_req <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_savestate_ctrl.sv
// Bench for savestate_ctrl: core and memory_stream behavioural models plus a slot-level
// reference of status, start pulses, region and slot_valid per command.
module tb_savestate_ctrl;
  localparam int          NS     = 4;
  localparam int          TW     = 10;
  localparam int          LIMIT  = (1 << TW) - 1;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] SLOTSZ = 32'h0040_0000;

  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_save = 1'b0, cmd_load = 1'b0;
  logic [3:0] cmd_slot = 4'd0;
  logic core_paused = 1'b0, ms_busy = 1'b0;
  logic cmd_ready, core_pause_req, ms_read_start, ms_write_start, done;
  logic [31:0] ms_start_addr, ms_length;
  logic [1:0] status;
  logic [NS-1:0] slot_valid;

  savestate_ctrl #(.BASE_ADDR(BASE), .SLOT_SIZE_LOG2(22), .NUM_SLOTS(NS), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .cmd_slot(cmd_slot), .cmd_ready(cmd_ready), .core_pause_req(core_pause_req),
    .core_paused(core_paused), .ms_start_addr(ms_start_addr), .ms_length(ms_length),
    .ms_read_start(ms_read_start), .ms_write_start(ms_write_start), .ms_busy(ms_busy),
    .done(done), .status(status), .slot_valid(slot_valid));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0, n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, preq_cnt = 0;
  always @(negedge clk) begin
    if (ms_write_start) wr_cnt++;
    if (ms_read_start) rd_cnt++;
    if (done) done_cnt++;
    if (core_pause_req) preq_cnt++;
  end

  // Environment: core halts pause_dly cycles after request; stream stays busy busy_len cycles.
  int pause_dly = 2, resume_dly = 2, busy_len = 5, busy_pre = 0;
  bit never_pause = 0, never_resume = 0;
  int pcnt = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      core_paused = 1'b0; ms_busy = 1'b0; pcnt = 0; busy_cnt = 0;
    end else begin
      if (core_pause_req && !core_paused) begin
        if (!never_pause) begin
          if (pcnt >= pause_dly) begin core_paused = 1'b1; pcnt = 0; busy_cnt = busy_pre; end
          else pcnt++;
        end
      end else if (!core_pause_req && core_paused) begin
        if (!never_resume) begin
          if (pcnt >= resume_dly) begin core_paused = 1'b0; pcnt = 0; end
          else pcnt++;
        end
      end else pcnt = 0;
      if (ms_write_start || ms_read_start) busy_cnt = busy_len;
      ms_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  bit [NS-1:0] mv = '0;

  typedef struct {
    int lat; int st_lat; int wr; int rd; int dn; int preq;
    logic [1:0] status; logic [NS-1:0] valid; logic [31:0] addr; logic [31:0] len; bit ok;
  } obs_t;

  task automatic issue(input bit s, input bit l, input logic [3:0] slot, output obs_t o);
    int t0, w0, r0, d0, p0, guard;
    bit got;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 5000) begin @(negedge clk); guard++; end
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; p0 = preq_cnt;
    o.lat = -1; o.st_lat = -1; o.status = 'x; o.valid = 'x; o.addr = 'x; o.len = 'x;
    got = 0;
    cmd_save = s; cmd_load = l; cmd_slot = slot; t0 = cyc;
    for (int k = 0; k < 4000 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin cmd_save = 1'b0; cmd_load = 1'b0; end
      if ((ms_write_start || ms_read_start) && o.st_lat < 0) o.st_lat = cyc - t0;
      if (done === 1'b1) begin
        got = 1; o.lat = cyc - t0; o.status = status; o.valid = slot_valid;
        o.addr = ms_start_addr; o.len = ms_length;
      end
    end
    repeat (3) @(negedge clk);
    o.wr = wr_cnt - w0; o.rd = rd_cnt - r0; o.dn = done_cnt - d0; o.preq = preq_cnt - p0;
    o.ok = got;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL cmd_done_wait: no done within 4000 cycles, required one done pulse");
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    n_vec++; if (core_pause_req !== 1'b0) begin n_err++; $display("FAIL rst_pause_req: got %b want 0", core_pause_req); end
    n_vec++; if ({ms_read_start, ms_write_start, done} !== 3'b000) begin n_err++; $display("FAIL rst_pulses: got %b want 000", {ms_read_start, ms_write_start, done}); end
    n_vec++; if ({ms_start_addr, ms_length} !== 64'd0) begin n_err++; $display("FAIL rst_region: got %h want 0", {ms_start_addr, ms_length}); end
    n_vec++; if (status !== 2'd0) begin n_err++; $display("FAIL rst_status: got %0d want 0", status); end
    n_vec++; if (slot_valid !== '0) begin n_err++; $display("FAIL rst_slot_valid: got %b want 0", slot_valid); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_empty_load();
    obs_t o;
    issue(1'b0, 1'b1, 4'd2, o);
    n_vec++; if (o.status !== 2'd3) begin n_err++; $display("FAIL empty_status: got %0d want 3", o.status); end
    n_vec++; if (o.lat != 1) begin n_err++; $display("FAIL empty_latency: got %0d want 1", o.lat); end
    n_vec++; if (o.preq != 0 || o.wr + o.rd != 0) begin n_err++; $display("FAIL empty_side_effects: preq %0d starts %0d want 0 0", o.preq, o.wr + o.rd); end
    n_vec++; if (o.dn != 1) begin n_err++; $display("FAIL empty_done_count: got %0d want 1", o.dn); end
  endtask

  task automatic test_save_slot1();
    obs_t o;
    pause_dly = 3; busy_len = 10; busy_pre = 0;
    issue(1'b1, 1'b0, 4'd1, o);
    mv[1] = 1'b1;
    n_vec++; if (o.wr != 1 || o.rd != 0) begin n_err++; $display("FAIL save1_pulses: wr %0d rd %0d want 1 0", o.wr, o.rd); end
    n_vec++; if (o.addr !== 32'h3040_0000) begin n_err++; $display("FAIL save1_addr: got %h want 30400000", o.addr); end
    n_vec++; if (o.len !== 32'h0040_0000) begin n_err++; $display("FAIL save1_len: got %h want 00400000", o.len); end
    n_vec++; if (o.status !== 2'd0) begin n_err++; $display("FAIL save1_status: got %0d want 0", o.status); end
    n_vec++; if (o.valid !== 4'b0010) begin n_err++; $display("FAIL save1_valid: got %b want 0010", o.valid); end
    n_vec++; if (o.dn != 1) begin n_err++; $display("FAIL save1_done_count: got %0d want 1", o.dn); end
  endtask

  task automatic test_bad_slot_and_both();
    obs_t o;
    issue(1'b1, 1'b0, 4'd5, o);
    n_vec++; if (o.status !== 2'd2) begin n_err++; $display("FAIL bad_status: got %0d want 2", o.status); end
    n_vec++; if (o.wr + o.rd != 0 || o.preq != 0 || o.lat != 1) begin n_err++; $display("FAIL bad_side_effects: starts %0d preq %0d lat %0d want 0 0 1", o.wr + o.rd, o.preq, o.lat); end
    issue(1'b1, 1'b1, 4'd0, o);
    mv[0] = 1'b1;
    n_vec++; if (o.wr != 1 || o.rd != 0) begin n_err++; $display("FAIL both_is_save: wr %0d rd %0d want 1 0", o.wr, o.rd); end
    n_vec++; if (o.valid !== mv) begin n_err++; $display("FAIL both_valid: got %b want %b", o.valid, mv); end
  endtask

  task automatic test_min_latency_and_busy_hold();
    obs_t o;
    pause_dly = 0; busy_pre = 0; busy_len = 4;
    issue(1'b0, 1'b1, 4'd1, o);
    n_vec++; if (o.st_lat != 2) begin n_err++; $display("FAIL min_start_latency: got %0d want 2", o.st_lat); end
    pause_dly = 1; busy_pre = 8;
    issue(1'b0, 1'b1, 4'd1, o);
    n_vec++; if (o.st_lat != 11) begin n_err++; $display("FAIL busy_hold_start: got %0d want 11", o.st_lat); end
    n_vec++; if (o.rd != 1 || o.wr != 0 || o.status !== 2'd0) begin n_err++; $display("FAIL busy_hold_load: rd %0d wr %0d status %0d want 1 0 0", o.rd, o.wr, o.status); end
    busy_pre = 0;
  endtask

  task automatic test_timeouts();
    obs_t o;
    never_pause = 1;
    issue(1'b1, 1'b0, 4'd2, o);
    never_pause = 0;
    n_vec++; if (o.status !== 2'd1) begin n_err++; $display("FAIL pause_to_status: got %0d want 1", o.status); end
    n_vec++; if (o.wr + o.rd != 0) begin n_err++; $display("FAIL pause_to_start: got %0d pulses want 0", o.wr + o.rd); end
    n_vec++; if (o.lat < LIMIT || o.lat > LIMIT + 3) begin n_err++; $display("FAIL pause_to_latency: got %0d want %0d..%0d", o.lat, LIMIT, LIMIT + 3); end
    n_vec++; if (core_pause_req !== 1'b0 || o.valid !== mv) begin n_err++; $display("FAIL pause_to_after: preq %b valid %b want 0 %b", core_pause_req, o.valid, mv); end
    never_resume = 1;
    issue(1'b1, 1'b0, 4'd3, o);
    never_resume = 0;
    mv[3] = 1'b1;
    repeat (resume_dly + 4) @(negedge clk);
    n_vec++; if (o.status !== 2'd1 || o.wr != 1) begin n_err++; $display("FAIL resume_to: status %0d wr %0d want 1 1", o.status, o.wr); end
    n_vec++; if (o.valid !== mv) begin n_err++; $display("FAIL resume_to_valid: got %b want %b", o.valid, mv); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int it = 0; it < 30; it++) begin
      int op, sl, es;
      bit sv, started;
      logic [31:0] ea;
      op = $urandom_range(0, 2); sl = $urandom_range(0, 6);
      pause_dly = $urandom_range(0, 4); busy_pre = $urandom_range(0, 3);
      busy_len = $urandom_range(0, 12); resume_dly = $urandom_range(0, 3);
      sv = (op != 1);
      started = 0;
      if (sl >= NS) es = 2;
      else if (!sv && !mv[sl]) es = 3;
      else begin es = 0; started = 1; end
      issue(sv, op != 0, 4'(sl), o);
      if (started && sv) mv[sl] = 1'b1;
      ea = BASE + 32'(sl) * SLOTSZ;
      n_vec++; if (o.status !== 2'(es)) begin n_err++; $display("FAIL rnd_status[%0d]: got %0d want %0d", it, o.status, es); end
      n_vec++; if (o.wr != int'(started && sv) || o.rd != int'(started && !sv)) begin n_err++; $display("FAIL rnd_pulses[%0d]: wr %0d rd %0d want %0d %0d", it, o.wr, o.rd, started && sv, started && !sv); end
      n_vec++; if (o.valid !== mv) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", it, o.valid, mv); end
      if (started) begin
        n_vec++; if (o.addr !== ea || o.len !== SLOTSZ) begin n_err++; $display("FAIL rnd_region[%0d]: got %h/%h want %h/%h", it, o.addr, o.len, ea, SLOTSZ); end
        n_vec++; if (o.st_lat != pause_dly + busy_pre + 2) begin n_err++; $display("FAIL rnd_start_lat[%0d]: got %0d want %0d", it, o.st_lat, pause_dly + busy_pre + 2); end
      end else begin
        n_vec++; if (o.lat != 1 || o.preq != 0) begin n_err++; $display("FAIL rnd_err_path[%0d]: lat %0d preq %0d want 1 0", it, o.lat, o.preq); end
      end
    end
    busy_pre = 0;
  endtask

  task automatic test_reset_mid_run();
    obs_t o;
    int guard, d0;
    pause_dly = 1; busy_len = 40;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    cmd_save = 1'b1; cmd_slot = 4'd0;
    @(negedge clk);
    cmd_save = 1'b0;
    guard = 0;
    while (ms_busy !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    repeat (5) @(negedge clk);
    n_vec++; if (core_pause_req !== 1'b1 || ms_busy !== 1'b1) begin n_err++; $display("FAIL mid_run_setup: preq %b busy %b want 1 1", core_pause_req, ms_busy); end
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (core_pause_req !== 1'b0) begin n_err++; $display("FAIL async_rst_preq: got %b want 0", core_pause_req); end
    n_vec++; if (cmd_ready !== 1'b1 || slot_valid !== '0) begin n_err++; $display("FAIL async_rst_state: ready %b valid %b want 1 0", cmd_ready, slot_valid); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mv = '0;
    repeat (4) @(negedge clk);
    n_vec++; if (done_cnt != d0) begin n_err++; $display("FAIL rst_no_done: got %0d extra done want 0", done_cnt - d0); end
    issue(1'b0, 1'b1, 4'd1, o);
    n_vec++; if (o.status !== 2'd3) begin n_err++; $display("FAIL post_rst_load: got %0d want 3", o.status); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty_load();
    test_save_slot1();
    test_bad_slot_and_both();
    test_min_latency_and_busy_hold();
    test_timeouts();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
